// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - dcache geometry, controller states and address-field helpers
package dcache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int NUM_LINES      = 32;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFF_W  = 2;
    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF_W + WORD_W + IDX_W));
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> (OFF_W + WORD_W));
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return WORD_W'(a >> OFF_W);
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// rtl/dcache_data_array.sv - cache data storage, async read, single sync write port
module dcache_data_array #(
    parameter int DATA_W    = 32,
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through dcache controller
// DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs; geometry comes from dcache_pkg.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int LINE_LSB = OFF_W + WORD_W;

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [WORD_W-1:0]    beat_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;

    logic [TAG_W-1:0]        cpu_tag;
    logic [IDX_W-1:0]        cpu_idx;
    logic [WORD_W-1:0]       cpu_word;
    logic [TAG_W-1:0]        ref_tag;
    logic [IDX_W-1:0]        ref_idx;
    logic                    hit;
    logic                    arr_we;
    logic [IDX_W+WORD_W-1:0] arr_waddr;
    logic [DATA_W-1:0]       arr_wdata;
    logic [DATA_W-1:0]       arr_rdata;

    assign cpu_tag  = addr_tag(cpu_addr);
    assign cpu_idx  = addr_index(cpu_addr);
    assign cpu_word = addr_word(cpu_addr);
    // The refill line address is held in mem_addr_q, so it does not depend on the CPU holding its inputs.
    assign ref_tag  = addr_tag(mem_addr_q);
    assign ref_idx  = addr_index(mem_addr_q);
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    assign arr_we    = rst_n && ((state_q == S_REFILL && mem_ready) ||
                                 (state_q == S_IDLE && cpu_wr && hit));
    assign arr_waddr = (state_q == S_REFILL) ? {ref_idx, beat_q} : {cpu_idx, cpu_word};
    assign arr_wdata = (state_q == S_REFILL) ? mem_rdata : cpu_wdata;

    dcache_data_array #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (IDX_W + WORD_W)
    ) u_data_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i ({cpu_idx, cpu_word}),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        stall     = 1'b0;
        cpu_rdata = '0;
        case (state_q)
            S_IDLE: begin
                if (cpu_wr) begin
                    stall = 1'b1;
                end else if (cpu_rd) begin
                    stall = !hit;
                    if (hit) begin
                        cpu_rdata = arr_rdata;
                    end
                end
            end
            S_REFILL: stall = 1'b1;
            S_WRITE:  stall = !mem_ready;
            default:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_wr) begin
                        state_q     <= S_WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {cpu_tag, cpu_idx, cpu_word, {OFF_W{1'b0}}};
                        mem_wdata_q <= cpu_wdata;
                    end else if (cpu_rd && !hit) begin
                        state_q          <= S_REFILL;
                        valid_q[cpu_idx] <= 1'b0;
                        beat_q           <= '0;
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b0;
                        mem_addr_q       <= {cpu_tag, cpu_idx, {LINE_LSB{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (&beat_q) begin
                            tag_q[ref_idx]   <= ref_tag;
                            valid_q[ref_idx] <= 1'b1;
                            state_q          <= S_IDLE;
                            mem_req_q        <= 1'b0;
                        end else begin
                            mem_addr_q <= {ref_tag, ref_idx, beat_q + 1'b1, {OFF_W{1'b0}}};
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == S_IDLE && cpu_rd && !cpu_wr) begin
            if (hit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (!hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst_n, cpu_rd, cpu_wr, stall, mem_req, mem_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Main memory: written locations remembered, others follow a fixed pattern.
    logic [31:0] mem_store [logic [31:0]];
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // Reference cache: which tag each of the 32 lines holds (16-byte lines).
    bit          mv [32];
    logic [22:0] mt [32];
    function automatic bit m_hit(input logic [31:0] a);
        return mv[a[8:4]] && (mt[a[8:4]] == a[31:9]);
    endfunction
    function automatic void m_fill(input logic [31:0] a);
        mv[a[8:4]] = 1'b1;
        mt[a[8:4]] = a[31:9];
    endfunction
    function automatic void m_clear();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    endfunction

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    beat_t beats[$];

    int fixed_delay = 0;
    int pend        = 0;
    int waits       = 0;
    bit inject      = 1'b0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (inject) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
                inject    = 1'b0;
            end else if (mem_req && rst_n) begin
                if (pend == 0) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                        beats.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
                    end else begin
                        mem_rdata = mem_val(mem_addr);
                        beats.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
                    end
                    pend = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
                end else begin
                    pend--;
                    waits++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    logic [31:0] got_rdata;
    logic        req_at_done;
    int          stall_cycles;

    // Entered and left at posedge+1; holds the request until stall drops.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        beats.delete();
        waits        = 0;
        stall_cycles = 0;
        cpu_rd       = rd;
        cpu_wr       = wr;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        forever begin
            @(negedge clk);
            if (!stall) begin
                got_rdata   = cpu_rdata;
                req_at_done = mem_req;
                break;
            end
            stall_cycles++;
            if (stall_cycles > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required release", addr, stall_cycles);
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mem_outputs: got req=%b we=%b addr=%h wdata=%h required all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({stall, cpu_rdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_cpu_outputs: got stall=%b rdata=%h required 0/0", stall, cpu_rdata);
        end
        rst_n = 1'b1;
        m_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_refill();
        fixed_delay = 0;
        pend        = 0;
        access(1'b1, 1'b0, 32'h100, 32'h0);
        n_checks++;
        if (stall_cycles != 5) begin
            n_fail++;
            $display("FAIL refill_latency: got %0d stall cycles required 5", stall_cycles);
        end
        n_checks++;
        if (beats.size() != 4) begin
            n_fail++;
            $display("FAIL refill_beat_count: got %0d required 4", beats.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (beats[i].we !== 1'b0 || beats[i].addr !== 32'h100 + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL refill_beat%0d: got we=%b addr=%h required 0/%h", i, beats[i].we, beats[i].addr, 32'h100 + 32'(4 * i));
                end
            end
        end
        n_checks++;
        if (got_rdata !== mem_val(32'h100)) begin
            n_fail++;
            $display("FAIL refill_rdata: got %h required %h", got_rdata, mem_val(32'h100));
        end
        m_fill(32'h100);
    endtask

    task automatic test_hit();
        access(1'b1, 1'b0, 32'h108, 32'h0);
        n_checks++;
        if (stall_cycles != 0 || beats.size() != 0 || req_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_no_stall: got stall_cycles=%0d beats=%0d req=%b required 0/0/0", stall_cycles, beats.size(), req_at_done);
        end
        n_checks++;
        if (got_rdata !== mem_val(32'h108)) begin
            n_fail++;
            $display("FAIL hit_rdata: got %h required %h", got_rdata, mem_val(32'h108));
        end
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF);
        n_checks++;
        if (beats.size() != 1 || beats[0].we !== 1'b1 || beats[0].addr !== 32'h104 || beats[0].data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_hit_beat: got %0d beats, first we=%b addr=%h data=%h required 1 beat 1/104/deadbeef",
                     beats.size(), beats[0].we, beats[0].addr, beats[0].data);
        end
        n_checks++;
        if (stall_cycles != 1) begin
            n_fail++;
            $display("FAIL write_hit_stall: got %0d required 1", stall_cycles);
        end
        access(1'b1, 1'b0, 32'h104, 32'h0);
        n_checks++;
        if (stall_cycles != 0 || got_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_hit_readback: got stall_cycles=%0d rdata=%h required 0/deadbeef", stall_cycles, got_rdata);
        end
    endtask

    task automatic test_write_miss();
        access(1'b0, 1'b1, 32'h4000, 32'h1234_5678);
        n_checks++;
        if (beats.size() != 1 || beats[0].we !== 1'b1 || beats[0].addr !== 32'h4000) begin
            n_fail++;
            $display("FAIL write_miss_beat: got %0d beats, first we=%b addr=%h required 1 write beat at 4000",
                     beats.size(), beats[0].we, beats[0].addr);
        end
        access(1'b1, 1'b0, 32'h4000, 32'h0);
        n_checks++;
        if (stall_cycles != 5 || beats.size() != 4 || got_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_miss_no_allocate: got stall_cycles=%0d beats=%0d rdata=%h required 5/4/12345678",
                     stall_cycles, beats.size(), got_rdata);
        end
        m_fill(32'h4000);
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3] = '{32'h100, 32'h300, 32'h100};
        int          exp_stall [3] = '{0, 5, 5};
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, seq[i], 32'h0);
            n_checks++;
            if (stall_cycles != exp_stall[i] || got_rdata !== mem_val(seq[i])) begin
                n_fail++;
                $display("FAIL conflict_%0d: addr %h got stall_cycles=%0d rdata=%h required %0d/%h",
                         i, seq[i], stall_cycles, got_rdata, exp_stall[i], mem_val(seq[i]));
            end
            m_fill(seq[i]);
        end
    endtask

    task automatic test_rd_wr_both();
        access(1'b1, 1'b1, 32'h108, 32'hA5A5_0108);
        n_checks++;
        if (beats.size() != 1 || beats[0].we !== 1'b1 || beats[0].data !== 32'hA5A5_0108) begin
            n_fail++;
            $display("FAIL rd_wr_write_wins: got %0d beats, first we=%b data=%h required 1 write of a5a50108",
                     beats.size(), beats[0].we, beats[0].data);
        end
        access(1'b1, 1'b0, 32'h108, 32'h0);
        n_checks++;
        if (stall_cycles != 0 || got_rdata !== 32'hA5A5_0108) begin
            n_fail++;
            $display("FAIL rd_wr_readback: got stall_cycles=%0d rdata=%h required 0/a5a50108", stall_cycles, got_rdata);
        end
    endtask

    task automatic test_spurious_ready();
        @(negedge clk);
        inject = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ready_idle: got req=%b stall=%b required 0/0", mem_req, stall);
        end
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h100, 32'h0);
        n_checks++;
        if (stall_cycles != 0 || got_rdata !== mem_val(32'h100)) begin
            n_fail++;
            $display("FAIL spurious_ready_hit: got stall_cycles=%0d rdata=%h required 0/%h", stall_cycles, got_rdata, mem_val(32'h100));
        end
    endtask

    task automatic test_reset_mid_refill();
        int guard = 0;
        fixed_delay = 1;
        pend        = 1;
        beats.delete();
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 32'h500;
        do begin
            @(negedge clk);
            guard++;
        end while (beats.size() < 2 && guard < 50);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h508) begin
            n_fail++;
            $display("FAIL midrefill_beat2: got req=%b addr=%h required 1/508", mem_req, mem_addr);
        end
        rst_n  = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midrefill_reset: got req=%b addr=%h stall=%b required 0/0/0", mem_req, mem_addr, stall);
        end
        rst_n = 1'b1;
        m_clear();
        @(posedge clk);
        #1;
        fixed_delay = 0;
        pend        = 0;
        access(1'b1, 1'b0, 32'h500, 32'h0);
        n_checks++;
        if (stall_cycles != 5 || beats.size() != 4 || beats[0].addr !== 32'h500 || got_rdata !== mem_val(32'h500)) begin
            n_fail++;
            $display("FAIL midrefill_retry: got stall_cycles=%0d beats=%0d first=%h rdata=%h required 5/4/500/%h",
                     stall_cycles, beats.size(), beats[0].addr, got_rdata, mem_val(32'h500));
        end
        m_fill(32'h500);
        access(1'b1, 1'b0, 32'h4000, 32'h0);
        n_checks++;
        if (stall_cycles != 5 || got_rdata !== mem_val(32'h4000)) begin
            n_fail++;
            $display("FAIL reset_clears_valid: got stall_cycles=%0d rdata=%h required 5/%h", stall_cycles, got_rdata, mem_val(32'h4000));
        end
        m_fill(32'h4000);
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata;
        bit          rd, wr, exp_hit;
        int          kind;
        fixed_delay = -1;
        for (int n = 0; n < 150; n++) begin
            addr  = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
            wdata = $urandom;
            kind  = int'($urandom_range(0, 3));
            rd    = (kind != 2);
            wr    = (kind >= 2);
            exp_hit = m_hit(addr);
            access(rd, wr, addr, wdata);
            if (wr) begin
                n_checks++;
                if (beats.size() != 1 || beats[0].we !== 1'b1 || beats[0].addr !== addr ||
                    beats[0].data !== wdata || stall_cycles != 1 + waits) begin
                    n_fail++;
                    $display("FAIL rand_write[%0d]: addr %h got beats=%0d stall_cycles=%0d required 1 beat, %0d cycles",
                             n, addr, beats.size(), stall_cycles, 1 + waits);
                end
            end else begin
                n_checks++;
                if (exp_hit ? (stall_cycles != 0 || beats.size() != 0)
                            : (stall_cycles != 5 + waits || beats.size() != 4 ||
                               beats[0].addr !== {addr[31:4], 4'h0} || beats[3].addr !== {addr[31:4], 4'hC})) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: addr %h hit=%b got stall_cycles=%0d beats=%0d required %0d cycles",
                             n, addr, exp_hit, stall_cycles, beats.size(), exp_hit ? 0 : 5 + waits);
                end
                n_checks++;
                if (got_rdata !== mem_val(addr)) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: addr %h got %h required %h", n, addr, got_rdata, mem_val(addr));
                end
                m_fill(addr);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        test_reset();
        test_refill();
        test_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_rd_wr_both();
        test_spurious_ready();
        test_reset_mid_refill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
